uart_tx_ring: RTL and testbench

//  Transmit-side ring buffer between the picorv32 data-register bus and the uart core's transmit port.
//  - Accepts bytes from CPU writes and queues them in a 2**RING_SIZE_TX entry ring.
//  - Drains the ring one byte at a time, pulsing tx_load only while the core is idle.
//  - The CPU can burst up to the ring depth without polling txbusy.

---
 rtl/uart_tx_ring.sv | 152 +++++++++++++++
 tb/tb_uart_tx_ring.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ring.sv
// Transmit ring between the picorv32 data-register bus and the uart core transmit port.
// CPU writes are queued in a 2**RING_SIZE_TX entry ring and handed to the core one byte per tx_load.
`timescale 1ns/1ps
module uart_tx_ring #(
    parameter int RING_SIZE_TX  = 2,
    parameter int STALL_ON_FULL = 1,
    parameter int BUSY_TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        reg_dat_we,
    input  logic [31:0] reg_dat_di,
    output logic        reg_dat_wait,
    input  logic        reg_state_re,
    output logic [31:0] reg_state_do,
    input  logic        tx_busy,
    output logic        tx_load,
    output logic [7:0]  tx_data
);
    localparam int DEPTH = 1 << RING_SIZE_TX;
    localparam int CW    = RING_SIZE_TX + 1;
    localparam int TW    = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);
    localparam logic STALL = (STALL_ON_FULL != 0);
    localparam logic [RING_SIZE_TX-1:0] PTR_ONE = RING_SIZE_TX'(1);
    localparam logic [CW-1:0]           CNT_ONE = CW'(1);
    localparam logic [TW-1:0]           TMR_ONE = TW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [RING_SIZE_TX-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]           count_q, count_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [7:0]              ring_q [DEPTH];
    logic [7:0]              ring_d [DEPTH];
    logic                    ovf_q, ovf_d;
    logic                    tx_load_q, tx_load_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    full_s, empty_s, push_s, pop_s, drop_s;
    logic [8:0]              count_ext_s;
    logic                    unused_di_s;

    assign unused_di_s = ^reg_dat_di[31:8];

    // Occupancy flags, push/pop qualification and the status word, all from registered count.
    always_comb begin
        full_s       = (count_q == CW'(DEPTH));
        empty_s      = (count_q == {CW{1'b0}});
        push_s       = reg_dat_we && !full_s;
        drop_s       = reg_dat_we && full_s && !STALL;
        pop_s        = (state_q == S_IDLE) && !empty_s && !tx_busy;
        reg_dat_wait = reg_dat_we && full_s && STALL;
        count_ext_s  = 9'(count_q);
        reg_state_do = {16'h0000, count_ext_s[7:0], 5'b00000, ovf_q, full_s, empty_s};
    end

    // Ring storage, pointers, occupancy count, presented byte and sticky overflow.
    always_comb begin
        ring_d    = ring_q;
        tail_d    = tail_q;
        head_d    = head_q;
        count_d   = count_q;
        tx_data_d = tx_data_q;
        ovf_d     = ovf_q;
        if (push_s) begin
            ring_d[tail_q] = reg_dat_di[7:0];
            tail_d         = tail_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            tx_data_d = ring_q[head_q];
            head_d    = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // A dropped write on the same edge as a status read keeps the flag set.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (reg_state_re) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Handshake FSM: pop in IDLE, then wait for the core's busy pulse or give up after the timeout.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        tx_load_d = (state_q == S_LOAD);
        case (state_q)
            S_IDLE: begin
                if (pop_s) state_d = S_LOAD;
                else       state_d = S_IDLE;
            end
            S_LOAD: begin
                state_d = S_WAIT_HI;
                timer_d = {TW{1'b0}};
            end
            S_WAIT_HI: begin
                if (tx_busy)                               state_d = S_WAIT_LO;
                else if (timer_q == TW'(BUSY_TIMEOUT))     state_d = S_IDLE;
                else                                       timer_d = timer_q + TMR_ONE;
            end
            S_WAIT_LO: begin
                if (!tx_busy) state_d = S_IDLE;
                else          state_d = S_WAIT_LO;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            head_q    <= {RING_SIZE_TX{1'b0}};
            tail_q    <= {RING_SIZE_TX{1'b0}};
            count_q   <= {CW{1'b0}};
            timer_q   <= {TW{1'b0}};
            ovf_q     <= 1'b0;
            tx_load_q <= 1'b0;
            tx_data_q <= 8'h00;
            for (int i = 0; i < DEPTH; i++) ring_q[i] <= 8'h00;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            ovf_q     <= ovf_d;
            tx_load_q <= tx_load_d;
            tx_data_q <= tx_data_d;
            ring_q    <= ring_d;
        end
    end

    assign tx_load = tx_load_q;
    assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_ring.sv
// Bench for uart_tx_ring: a stalling ring (A) and a dropping ring (B), each with a uart core
// model and a scoreboard monitor that matches every tx_load against the bytes the CPU wrote.
`timescale 1ns/1ps
module tb_uart_tx_ring;
    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        a_we = 1'b0, a_re = 1'b0, a_wait, a_load, a_busy;
    logic [31:0] a_di = 32'h0, a_do;
    logic [7:0]  a_data;
    logic        a_stuck = 1'b0, a_mute = 1'b0, a_core_busy = 1'b0, a_prev_load = 1'b0;
    logic        b_we = 1'b0, b_re = 1'b0, b_wait, b_load, b_busy;
    logic [31:0] b_di = 32'h0, b_do;
    logic [7:0]  b_data;
    logic        b_stuck = 1'b1, b_core_busy = 1'b0, b_prev_load = 1'b0;
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    int          checks = 0, errors = 0;
    int          loads_a = 0, loads_b = 0, writes_a = 0;

    assign a_busy = a_stuck | a_core_busy;
    assign b_busy = b_stuck | b_core_busy;

    always #5 clk = ~clk;

    uart_tx_ring #(.RING_SIZE_TX(2), .STALL_ON_FULL(1), .BUSY_TIMEOUT(TMO)) u_dut_a (
        .clk(clk), .resetn(resetn), .reg_dat_we(a_we), .reg_dat_di(a_di), .reg_dat_wait(a_wait),
        .reg_state_re(a_re), .reg_state_do(a_do), .tx_busy(a_busy), .tx_load(a_load), .tx_data(a_data));

    uart_tx_ring #(.RING_SIZE_TX(2), .STALL_ON_FULL(0), .BUSY_TIMEOUT(TMO)) u_dut_b (
        .clk(clk), .resetn(resetn), .reg_dat_we(b_we), .reg_dat_di(b_di), .reg_dat_wait(b_wait),
        .reg_state_re(b_re), .reg_state_do(b_do), .tx_busy(b_busy), .tx_load(b_load), .tx_data(b_data));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard for ring A.
    always begin
        @(posedge clk); #1;
        if (a_load) begin
            loads_a++;
            chk("a_load_single_cycle", 32'(a_prev_load), 32'd0);
            if (exp_a.size() == 0) chk("a_load_pending", 32'(exp_a.size()), 32'd1);
            else                   chk("a_load_data", 32'(a_data), 32'(exp_a.pop_front()));
        end
        a_prev_load = a_load;
    end

    // Scoreboard for ring B.
    always begin
        @(posedge clk); #1;
        if (b_load) begin
            loads_b++;
            chk("b_load_single_cycle", 32'(b_prev_load), 32'd0);
            if (exp_b.size() == 0) chk("b_load_pending", 32'(exp_b.size()), 32'd1);
            else                   chk("b_load_data", 32'(b_data), 32'(exp_b.pop_front()));
        end
        b_prev_load = b_load;
    end

    // Uart core model A: busy rises 1..3 cycles after a load and stays high 1..6 cycles.
    always begin
        @(posedge clk); #1;
        if (a_load && !a_mute) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1 a_core_busy = 1'b1;
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1 a_core_busy = 1'b0;
        end
    end

    // Uart core model B.
    always begin
        @(posedge clk); #1;
        if (b_load) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1 b_core_busy = 1'b1;
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1 b_core_busy = 1'b0;
        end
    end

    // Called #1 after a rising edge; holds the write until the ring accepts it.
    task automatic a_write(input logic [7:0] b);
        logic st;
        int   n;
        st = 1'b0;
        n  = 0;
        a_we = 1'b1;
        a_di = $urandom();
        a_di[7:0] = b;
        exp_a.push_back(b);
        writes_a++;
        do begin
            @(negedge clk);
            st = a_wait;
            @(posedge clk);
            n++;
        end while (st && n < 200);
        #1 a_we = 1'b0;
        if (st) chk("a_write_stall_timeout", 32'(n), 32'd0);
    endtask

    // Ring B never stalls; the bench's FIFO only keeps bytes that fit (core held busy meanwhile).
    task automatic b_write(input logic [7:0] b);
        b_we = 1'b1;
        b_di = $urandom();
        b_di[7:0] = b;
        if (exp_b.size() < DEPTH) exp_b.push_back(b);
        @(negedge clk);
        chk("b_wait_low", 32'(b_wait), 32'd0);
        @(posedge clk);
        #1 b_we = 1'b0;
    endtask

    task automatic a_drain();
        int n;
        n = 0;
        while (exp_a.size() != 0 && n < 1000) begin @(posedge clk); #1; n++; end
        repeat (12) @(posedge clk);
        while (a_busy && n < 1000) begin @(posedge clk); #1; n++; end
        repeat (3) @(posedge clk);
        #1;
        if (n >= 1000) chk("a_drain_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] st;
        logic [7:0]  lvl;
        int          n, snap;

        repeat (3) @(posedge clk);
        #1;
        chk("a_reset_status", a_do, 32'h0000_0001);
        chk("a_reset_load", 32'(a_load), 32'd0);
        chk("a_reset_data", 32'(a_data), 32'd0);
        chk("a_reset_wait", 32'(a_wait), 32'd0);
        chk("b_reset_status", b_do, 32'h0000_0001);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk);
        #1;

        // Single byte into an empty ring: load appears in the cycle after the second following edge.
        a_write(8'h41);
        chk("t1_load_at_k", 32'(a_load), 32'd0);
        @(posedge clk); #1;
        chk("t1_level_after_pop", 32'(a_do[15:8]), 32'd0);
        chk("t1_load_at_k1", 32'(a_load), 32'd0);
        @(posedge clk); #1;
        chk("t1_load_at_k2", 32'(a_load), 32'd1);
        chk("t1_data", 32'(a_data), 32'h41);
        a_drain();

        // Fill with the core busy, then stall a fifth write until one byte drains.
        a_stuck = 1'b1;
        for (int i = 0; i < 4; i++) a_write(8'(8'h41 + i));
        @(negedge clk);
        chk("t2_level", 32'(a_do[15:8]), 32'd4);
        chk("t2_full", 32'(a_do[1]), 32'd1);
        chk("t2_empty", 32'(a_do[0]), 32'd0);
        a_we = 1'b1;
        a_di = 32'h0000_0055;
        exp_a.push_back(8'h55);
        writes_a++;
        #1;
        chk("t3_wait_full", 32'(a_wait), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("t3_wait_held", 32'(a_wait), 32'd1);
        end
        chk("t3_level_held", 32'(a_do[15:8]), 32'd4);
        a_stuck = 1'b0;
        @(posedge clk); #1;
        chk("t3_wait_drop", 32'(a_wait), 32'd0);
        chk("t3_level_pop", 32'(a_do[15:8]), 32'd3);
        @(posedge clk); #1;
        a_we = 1'b0;
        chk("t3_level_back", 32'(a_do[15:8]), 32'd4);
        a_drain();

        // Random traffic with interleaved status reads.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            if ($urandom_range(0, 3) == 0) begin
                a_re = 1'b1;
                @(negedge clk);
                st  = a_do;
                lvl = st[15:8];
                chk("a_status_fmt", st, {16'h0000, lvl, 5'b00000, 1'b0, (lvl == 8'd4), (lvl == 8'd0)});
                chk("a_level_range", 32'(lvl <= 8'd4), 32'd1);
                @(posedge clk);
                #1 a_re = 1'b0;
            end
            a_write(8'($urandom()));
        end
        a_drain();
        chk("a_total_loads", 32'(loads_a), 32'(writes_a));

        // Core never answers: the byte is retired after the timeout and the next one loads.
        a_mute = 1'b1;
        a_write(8'($urandom()));
        a_write(8'($urandom()));
        n = 0;
        while (!a_load && n < 50) begin @(posedge clk); #1; n++; end
        chk("t5_first_load", 32'(a_load), 32'd1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!a_load && n < 60);
        chk("t5_timeout_gap", 32'(n), 32'(TMO + 3));
        repeat (TMO + 6) @(posedge clk);
        #1;
        a_drain();
        a_mute = 1'b0;

        // Dropping ring: fifth write is lost, ovf is sticky, read clears, drop beats read.
        for (int i = 0; i < 5; i++) b_write((i == 4) ? 8'h66 : 8'($urandom()));
        chk("t4_level", 32'(b_do[15:8]), 32'd4);
        chk("t4_ovf_set", 32'(b_do[2]), 32'd1);
        b_re = 1'b1;
        @(negedge clk);
        chk("t4_read_sees_ovf", 32'(b_do[2]), 32'd1);
        @(posedge clk);
        #1 b_re = 1'b0;
        chk("t4_ovf_cleared", 32'(b_do[2]), 32'd0);
        b_re = 1'b1;
        b_write(8'($urandom()));
        b_re = 1'b0;
        chk("t4_set_wins", 32'(b_do[2]), 32'd1);
        chk("t4_level_kept", 32'(b_do[15:8]), 32'd4);
        b_re = 1'b1;
        @(posedge clk);
        #1 b_re = 1'b0;
        chk("t4_ovf_clear2", 32'(b_do[2]), 32'd0);
        b_stuck = 1'b0;
        n = 0;
        while (exp_b.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
        repeat (12) @(posedge clk);
        #1;
        chk("t4_loads", 32'(loads_b), 32'd4);
        chk("t4_empty_after", b_do, 32'h0000_0001);

        // Reset while waiting for busy to fall with three bytes still queued.
        a_mute = 1'b1;
        for (int i = 0; i < 4; i++) a_write(8'($urandom()));
        a_stuck = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_level_before", 32'(a_do[15:8]), 32'd3);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("t6_level_reset", 32'(a_do[15:8]), 32'd0);
        chk("t6_load_reset", 32'(a_load), 32'd0);
        chk("t6_empty_reset", 32'(a_do[0]), 32'd1);
        exp_a.delete();
        @(negedge clk);
        resetn  = 1'b1;
        a_stuck = 1'b0;
        snap = loads_a;
        repeat (30) @(posedge clk);
        #1;
        chk("t6_no_loads", 32'(loads_a), 32'(snap));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
